// File: rtl/i2c_master_wrapper_if.sv
// MicroBlaze-style slot bus between the CPU and the I2C master.
interface i2c_master_wrapper_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, read, write, reg_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, reg_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/i2c_master_wrapper.sv
// I2C master controller: START / repeated START / byte write / byte read / STOP
// on an open-drain SCL/SDA pair, one command at a time, status polled by the CPU.
module i2c_master_wrapper #(
  parameter int unsigned DEFAULT_DVSR = 250,
  parameter int unsigned DVSR_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                reset,
  i2c_master_wrapper_if.slave bus,
  inout  tri                  scl,
  inout  tri                  sda
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] START1   = 4'd1;
  localparam logic [3:0] START2   = 4'd2;
  localparam logic [3:0] HOLD     = 4'd3;
  localparam logic [3:0] RESTART1 = 4'd4;
  localparam logic [3:0] RESTART2 = 4'd5;
  localparam logic [3:0] DATA1    = 4'd6;
  localparam logic [3:0] DATA2    = 4'd7;
  localparam logic [3:0] DATA3    = 4'd8;
  localparam logic [3:0] DATA4    = 4'd9;
  localparam logic [3:0] STOP1    = 4'd10;
  localparam logic [3:0] STOP2    = 4'd11;
  localparam logic [3:0] STOP3    = 4'd12;

  localparam logic [2:0] CMD_START = 3'd0;
  localparam logic [2:0] CMD_WR    = 3'd1;
  localparam logic [2:0] CMD_RD    = 3'd2;
  localparam logic [2:0] CMD_STOP  = 3'd3;

  localparam logic [DVSR_WIDTH-1:0] MIN_DVSR = DVSR_WIDTH'(4);

  logic [3:0]            state_q, state_d;
  logic [DVSR_WIDTH-1:0] tmr_q, tmr_d;
  logic [DVSR_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [8:0]            tx_q, tx_d;     // bit 8 is the bit currently on the wire
  logic [8:0]            rx_sr_q, rx_sr_d;
  logic [3:0]            bit_q, bit_d;
  logic                  rd_cmd_q, rd_cmd_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  ack_q, ack_d;
  logic                  sda_meta, sda_sync;

  logic                  wr, ready, bus_held, phase_end;
  logic [2:0]            cmd;
  logic [7:0]            data;
  logic [DVSR_WIDTH-1:0] dvsr_in;
  logic                  scl_rel, sda_rel;
  logic                  unused_bits;

  assign wr        = bus.cs & bus.write;
  assign cmd       = bus.wr_data[10:8];
  assign data      = bus.wr_data[7:0];
  assign dvsr_in   = bus.wr_data[DVSR_WIDTH-1:0];
  assign ready     = (state_q == IDLE) || (state_q == HOLD);
  assign bus_held  = (state_q == HOLD);
  // Only the non-resting states are timed; the last cycle of a phase advances the FSM.
  assign phase_end = !ready && (tmr_q == dvsr_q - DVSR_WIDTH'(1));

  // Reads have no side effects, so the strobe is not needed.
  assign unused_bits = ^{bus.read, bus.wr_data};

  assign bus.rd_data = {21'h0, bus_held, ack_q, ready, rx_data_q};

  // Next-state logic: command/divisor acceptance, phase timer, bit sequencing.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    dvsr_d    = dvsr_q;
    tx_d      = tx_q;
    rx_sr_d   = rx_sr_q;
    bit_d     = bit_q;
    rd_cmd_d  = rd_cmd_q;
    rx_data_d = rx_data_q;
    ack_d     = ack_q;

    if (!ready) begin
      tmr_d = phase_end ? '0 : tmr_q + DVSR_WIDTH'(1);
    end

    if (wr && ready) begin
      if (bus.reg_addr == 5'd0) begin
        dvsr_d = (dvsr_in < MIN_DVSR) ? MIN_DVSR : dvsr_in;
      end else if (bus.reg_addr == 5'd1) begin
        case (cmd)
          CMD_START: begin
            state_d = bus_held ? RESTART1 : START1;
            tmr_d   = '0;
          end
          CMD_WR: if (bus_held) begin
            state_d  = DATA1;
            tmr_d    = '0;
            bit_d    = '0;
            rd_cmd_d = 1'b0;
            tx_d     = {data, 1'b1};  // release SDA for the slave's ACK
          end
          CMD_RD: if (bus_held) begin
            state_d  = DATA1;
            tmr_d    = '0;
            bit_d    = '0;
            rd_cmd_d = 1'b1;
            tx_d     = {8'hff, data[0]};  // release for the byte, then our ACK/NACK
          end
          CMD_STOP: if (bus_held) begin
            state_d = STOP1;
            tmr_d   = '0;
          end
          default: ;
        endcase
      end
    end

    if (phase_end) begin
      case (state_q)
        START1:   state_d = START2;
        START2:   state_d = HOLD;
        RESTART1: state_d = RESTART2;
        RESTART2: state_d = START1;
        DATA1:    state_d = DATA2;
        DATA2: begin
          state_d = DATA3;
          rx_sr_d = {rx_sr_q[7:0], sda_sync};
        end
        DATA3:    state_d = DATA4;
        DATA4: begin
          if (bit_q == 4'd8) begin
            state_d = HOLD;
            if (rd_cmd_q) rx_data_d = rx_sr_q[8:1];
            else          ack_d     = ~rx_sr_q[0];
          end else begin
            state_d = DATA1;
            bit_d   = bit_q + 4'd1;
            tx_d    = {tx_q[7:0], 1'b1};
          end
        end
        STOP1:    state_d = STOP2;
        STOP2:    state_d = STOP3;
        STOP3:    state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset aborts any transfer in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      dvsr_q    <= DVSR_WIDTH'(DEFAULT_DVSR);
      tx_q      <= '1;
      rx_sr_q   <= '0;
      bit_q     <= '0;
      rd_cmd_q  <= 1'b0;
      rx_data_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      dvsr_q    <= dvsr_d;
      tx_q      <= tx_d;
      rx_sr_q   <= rx_sr_d;
      bit_q     <= bit_d;
      rd_cmd_q  <= rd_cmd_d;
      rx_data_q <= rx_data_d;
      ack_q     <= ack_d;
    end
  end

  // Two-flop synchronizer for the asynchronous SDA line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= sda;
      sda_sync <= sda_meta;
    end
  end

  // Line levels decoded from state so a reset releases the bus at once (1 = released).
  always_comb begin
    scl_rel = 1'b1;
    sda_rel = 1'b1;
    case (state_q)
      IDLE:     begin scl_rel = 1'b1; sda_rel = 1'b1;    end
      START1:   begin scl_rel = 1'b1; sda_rel = 1'b0;    end
      START2:   begin scl_rel = 1'b0; sda_rel = 1'b0;    end
      HOLD:     begin scl_rel = 1'b0; sda_rel = 1'b0;    end
      RESTART1: begin scl_rel = 1'b0; sda_rel = 1'b1;    end
      RESTART2: begin scl_rel = 1'b1; sda_rel = 1'b1;    end
      DATA1:    begin scl_rel = 1'b0; sda_rel = tx_q[8]; end
      DATA2:    begin scl_rel = 1'b1; sda_rel = tx_q[8]; end
      DATA3:    begin scl_rel = 1'b1; sda_rel = tx_q[8]; end
      DATA4:    begin scl_rel = 1'b0; sda_rel = tx_q[8]; end
      STOP1:    begin scl_rel = 1'b0; sda_rel = 1'b0;    end
      STOP2:    begin scl_rel = 1'b1; sda_rel = 1'b0;    end
      STOP3:    begin scl_rel = 1'b1; sda_rel = 1'b1;    end
      default:  begin scl_rel = 1'b1; sda_rel = 1'b1;    end
    endcase
  end

  assign scl = scl_rel ? 1'bz : 1'b0;
  assign sda = sda_rel ? 1'bz : 1'b0;

endmodule

// File: tb/tb_i2c_master_wrapper.sv
// Directed bench for i2c_master_wrapper with a simple scripted I2C slave and a scoreboard queue.
module tb_i2c_master_wrapper;

  logic clk = 1'b0;
  logic reset;
  wire  scl;
  wire  sda;
  logic slave_drv;

  i2c_master_wrapper_if bus ();

  i2c_master_wrapper #(
    .DEFAULT_DVSR (250),
    .DVSR_WIDTH   (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .scl   (scl),
    .sda   (sda)
  );

  pullup (scl);
  pullup (sda);
  assign sda = slave_drv ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Observations gathered while a command runs.
  int         lat, pulses, sda_fall_cyc, sda_fall_scl, sda_rise_cyc, sda_rise_scl, scl_fall_cyc;
  logic [8:0] bits;
  logic       prev_scl, prev_sda;
  int         slave_mode;  // 0 idle, 1 ACK a written byte, 2 send slave_byte
  logic [7:0] slave_byte;

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h required <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic slot_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs       = 1'b1;
    bus.write    = 1'b1;
    bus.reg_addr = a;
    bus.wr_data  = d;
    @(posedge clk);
    #1;
    bus.cs    = 1'b0;
    bus.write = 1'b0;
  endtask

  // Samples the bus each cycle until ready returns (or the budget runs out; lat stays -1).
  task automatic watch(input int max_cyc);
    logic cur_scl, cur_sda;
    lat = -1; pulses = 0; bits = '0;
    sda_fall_cyc = -1; sda_fall_scl = -1; sda_rise_cyc = -1; sda_rise_scl = -1;
    scl_fall_cyc = -1;
    for (int c = 0; c <= max_cyc; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      cur_scl = scl;
      cur_sda = sda;
      if (prev_sda === 1'b1 && cur_sda === 1'b0 && sda_fall_cyc < 0) begin
        sda_fall_cyc = c;
        sda_fall_scl = int'(cur_scl);
      end
      if (prev_sda === 1'b0 && cur_sda === 1'b1 && sda_rise_cyc < 0) begin
        sda_rise_cyc = c;
        sda_rise_scl = int'(cur_scl);
      end
      if (prev_scl === 1'b0 && cur_scl === 1'b1) begin
        pulses++;
        bits = {bits[7:0], cur_sda};
      end
      if (prev_scl === 1'b1 && cur_scl === 1'b0) begin
        if (scl_fall_cyc < 0) scl_fall_cyc = c;
        if (slave_mode == 1) slave_drv = (pulses == 8);
        else if (slave_mode == 2) slave_drv = (pulses < 8) ? ~slave_byte[7 - pulses] : 1'b0;
      end
      prev_scl = cur_scl;
      prev_sda = cur_sda;
      if (bus.rd_data[8] === 1'b1) begin
        lat = c;
        break;
      end
    end
    slave_drv  = 1'b0;
    slave_mode = 0;
  endtask

  task automatic run_cmd(input logic [31:0] d, input int max_cyc);
    @(negedge clk);
    prev_scl = scl;
    prev_sda = sda;
    slot_write(5'd1, d);
    watch(max_cyc);
  endtask

  initial begin
    reset        = 1'b0;
    bus.cs       = 1'b0;
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.reg_addr = '0;
    bus.wr_data  = '0;
    slave_drv    = 1'b0;
    slave_mode   = 0;
    slave_byte   = '0;
    #23 reset = 1'b1;

    // Reset state
    @(negedge clk);
    sb_push("reset_rd_data", 32'h0000_0100);
    sb_push("reset_scl", 32'd1);
    sb_push("reset_sda", 32'd1);
    sb_check(bus.rd_data);
    sb_check({31'h0, scl});
    sb_check({31'h0, sda});

    // Divisor below the minimum is clamped to 4
    slot_write(5'd0, 32'd2);

    // START from IDLE
    sb_push("start_sda_fall_cyc", 32'd0);
    sb_push("start_sda_fall_scl", 32'd1);
    sb_push("start_scl_fall_cyc", 32'd4);
    sb_push("start_latency", 32'd8);
    sb_push("start_rd_data", 32'h0000_0500);
    run_cmd(32'h0000_0000, 50);
    sb_check(32'(sda_fall_cyc));
    sb_check(32'(sda_fall_scl));
    sb_check(32'(scl_fall_cyc));
    sb_check(32'(lat));
    sb_check(bus.rd_data);

    // WR 0x10, slave NACKs
    sb_push("wr_nack_latency", 32'd144);
    sb_push("wr_nack_pulses", 32'd9);
    sb_push("wr_nack_bits", 32'h0000_0021);
    sb_push("wr_nack_rd_data", 32'h0000_0500);
    slave_mode = 0;
    run_cmd(32'h0000_0110, 300);
    sb_check(32'(lat));
    sb_check(32'(pulses));
    sb_check({23'h0, bits});
    sb_check(bus.rd_data);

    // WR 0x10, slave ACKs
    sb_push("wr_ack_latency", 32'd144);
    sb_push("wr_ack_pulses", 32'd9);
    sb_push("wr_ack_bits", 32'h0000_0020);
    sb_push("wr_ack_rd_data", 32'h0000_0700);
    slave_mode = 1;
    run_cmd(32'h0000_0110, 300);
    sb_check(32'(lat));
    sb_check(32'(pulses));
    sb_check({23'h0, bits});
    sb_check(bus.rd_data);

    // Repeated START from HOLD
    sb_push("rstart_latency", 32'd16);
    sb_push("rstart_sda_fall_cyc", 32'd8);
    sb_push("rstart_sda_fall_scl", 32'd1);
    sb_push("rstart_rd_data", 32'h0000_0700);
    run_cmd(32'h0000_0000, 50);
    sb_check(32'(lat));
    sb_check(32'(sda_fall_cyc));
    sb_check(32'(sda_fall_scl));
    sb_check(bus.rd_data);

    // RD with NACK to slave; slave sends 0xA5; ack stays 1
    sb_push("rd_latency", 32'd144);
    sb_push("rd_pulses", 32'd9);
    sb_push("rd_bits", 32'h0000_014B);
    sb_push("rd_rd_data", 32'h0000_07A5);
    slave_mode = 2;
    slave_byte = 8'hA5;
    slave_drv  = ~slave_byte[7];
    run_cmd(32'h0000_0201, 300);
    sb_check(32'(lat));
    sb_check(32'(pulses));
    sb_check({23'h0, bits});
    sb_check(bus.rd_data);

    // STOP from HOLD
    sb_push("stop_latency", 32'd12);
    sb_push("stop_sda_rise_cyc", 32'd8);
    sb_push("stop_sda_rise_scl", 32'd1);
    sb_push("stop_rd_data", 32'h0000_03A5);
    run_cmd(32'h0000_0300, 50);
    sb_check(32'(lat));
    sb_check(32'(sda_rise_cyc));
    sb_check(32'(sda_rise_scl));
    sb_check(bus.rd_data);

    // WR in IDLE is ignored
    sb_push("idle_wr_rd_data_now", 32'h0000_03A5);
    sb_push("idle_wr_rd_data_later", 32'h0000_03A5);
    sb_push("idle_wr_scl", 32'd1);
    sb_push("idle_wr_sda", 32'd1);
    slot_write(5'd1, 32'h0000_0155);
    sb_check(bus.rd_data);
    repeat (3) @(posedge clk);
    #1;
    sb_check(bus.rd_data);
    sb_check({31'h0, scl});
    sb_check({31'h0, sda});

    // Divisor and command writes while busy are ignored
    sb_push("busy_start_latency", 32'd8);
    sb_push("busy_wr_latency", 32'd142);
    sb_push("busy_wr_rd_data", 32'h0000_05A5);
    sb_push("busy_rstart_latency", 32'd16);
    run_cmd(32'h0000_0000, 50);
    sb_check(32'(lat));
    slot_write(5'd1, 32'h0000_0110);
    slot_write(5'd0, 32'd8);
    slot_write(5'd1, 32'h0000_0300);
    prev_scl = scl;
    prev_sda = sda;
    watch(300);
    sb_check(32'(lat));
    sb_check(bus.rd_data);
    run_cmd(32'h0000_0000, 100);
    sb_check(32'(lat));

    // Reset in DATA4 of bit 4 of a WR 0x00
    sb_push("mid_scl_before", 32'd0);
    sb_push("mid_sda_before", 32'd0);
    sb_push("mid_scl_after_reset", 32'd1);
    sb_push("mid_sda_after_reset", 32'd1);
    sb_push("mid_rd_data_after_reset", 32'h0000_0100);
    slot_write(5'd1, 32'h0000_0100);
    repeat (60) @(posedge clk);
    #3;
    sb_check({31'h0, scl});
    sb_check({31'h0, sda});
    reset = 1'b0;
    #1;
    sb_check({31'h0, scl});
    sb_check({31'h0, sda});
    sb_check(bus.rd_data);
    #5 reset = 1'b1;

    // Divisor back at its default of 250
    sb_push("post_reset_start_latency", 32'd500);
    sb_push("post_reset_rd_data", 32'h0000_0500);
    run_cmd(32'h0000_0000, 1100);
    sb_check(32'(lat));
    sb_check(bus.rd_data);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
